// File: rtl/alu_flags_pkg.sv
// Shared flag types for the ALU flag pipeline: NZCV layout, bit indices and reset value.
package alu_flags_pkg;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam nzcv_t NZCV_RESET = '0;

  function automatic nzcv_t pack_nzcv(input logic n, input logic z, input logic c, input logic v);
    logic [3:0] tmp;
    tmp         = 4'b0000;
    tmp[FLAG_N] = n;
    tmp[FLAG_Z] = z;
    tmp[FLAG_C] = c;
    tmp[FLAG_V] = v;
    return nzcv_t'(tmp);
  endfunction

endpackage

// File: rtl/chunk_zero_reduce.sv
// First-stage zero detect: one zero bit per CHUNK-wide slice of the result.
// A partial top chunk only looks at the bits that exist, so padding never affects Z.
module chunk_zero_reduce #(
  parameter int WIDTH  = 64,
  parameter int CHUNK  = 8,
  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK
) (
  input  logic [WIDTH-1:0]  result_i,
  output logic [NCHUNK-1:0] cz_o
);

  for (genvar i = 0; i < NCHUNK; i++) begin : g_chunk
    localparam int LO = i * CHUNK;
    localparam int HI = ((LO + CHUNK) > WIDTH) ? (WIDTH - 1) : (LO + CHUNK - 1);
    assign cz_o[i] = ~|result_i[HI:LO];
  end

endmodule

// File: rtl/alu_flag_pipe.sv
// Two-stage zero-detect pipeline feeding the architectural NZCV register.
// Stage 1 holds the chunk-zero vector, stage 2 holds the folded Z; the next edge retires.
module alu_flag_pipe
  import alu_flags_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] result,
  input  logic             carry_in,
  input  logic             ovf_in,
  input  logic             set_flags,
  input  logic             flush,
  input  logic             load_en,
  input  logic [3:0]       load_flags,
  output logic             zero_out,
  output logic             res_valid,
  output logic [3:0]       flags,
  output logic             flags_pend
);

  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;

  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_cfg
    $fatal(1, "alu_flag_pipe: illegal WIDTH/CHUNK combination");
  end

  logic [NCHUNK-1:0] cz_s;

  logic              s1_valid_q, s1_valid_d;
  logic [NCHUNK-1:0] s1_cz_q, s1_cz_d;
  logic              s1_n_q, s1_n_d, s1_c_q, s1_c_d, s1_v_q, s1_v_d, s1_set_q, s1_set_d;
  logic              s2_valid_q, s2_valid_d;
  logic              s2_z_q, s2_z_d, s2_n_q, s2_n_d, s2_c_q, s2_c_d, s2_v_q, s2_v_d;
  logic              s2_set_q, s2_set_d;
  nzcv_t             flags_q, flags_d;
  logic              zero_q, zero_d;
  logic              res_valid_q, res_valid_d;
  logic              retire_s;

  chunk_zero_reduce #(.WIDTH(WIDTH), .CHUNK(CHUNK)) u_czr (
    .result_i (result),
    .cz_o     (cz_s)
  );

  // Next-state for both stages, the retire path and the flag register.
  always_comb begin
    s1_valid_d = in_valid & ~flush;
    s1_cz_d    = cz_s;
    s1_n_d     = result[WIDTH-1];
    s1_c_d     = carry_in;
    s1_v_d     = ovf_in;
    s1_set_d   = set_flags;

    s2_valid_d = s1_valid_q & ~flush;
    s2_z_d     = &s1_cz_q;
    s2_n_d     = s1_n_q;
    s2_c_d     = s1_c_q;
    s2_v_d     = s1_v_q;
    s2_set_d   = s1_set_q;

    retire_s    = s2_valid_q & ~flush;
    res_valid_d = retire_s;
    if (retire_s) begin
      zero_d = s2_z_q;
    end else begin
      zero_d = zero_q;
    end

    // A context-restore load overrides whatever the retiring op would have written.
    if (load_en) begin
      flags_d = nzcv_t'(load_flags);
    end else if (retire_s && s2_set_q) begin
      flags_d = pack_nzcv(s2_n_q, s2_z_q, s2_c_q, s2_v_q);
    end else begin
      flags_d = flags_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_cz_q     <= '0;
      s1_n_q      <= 1'b0;
      s1_c_q      <= 1'b0;
      s1_v_q      <= 1'b0;
      s1_set_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_z_q      <= 1'b0;
      s2_n_q      <= 1'b0;
      s2_c_q      <= 1'b0;
      s2_v_q      <= 1'b0;
      s2_set_q    <= 1'b0;
      flags_q     <= NZCV_RESET;
      zero_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_cz_q     <= s1_cz_d;
      s1_n_q      <= s1_n_d;
      s1_c_q      <= s1_c_d;
      s1_v_q      <= s1_v_d;
      s1_set_q    <= s1_set_d;
      s2_valid_q  <= s2_valid_d;
      s2_z_q      <= s2_z_d;
      s2_n_q      <= s2_n_d;
      s2_c_q      <= s2_c_d;
      s2_v_q      <= s2_v_d;
      s2_set_q    <= s2_set_d;
      flags_q     <= flags_d;
      zero_q      <= zero_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign flags_pend = (s1_valid_q & s1_set_q) | (s2_valid_q & s2_set_q);
  assign flags      = flags_q;
  assign zero_out   = zero_q;
  assign res_valid  = res_valid_q;

endmodule
